// File: rtl/spi_frame_decoder.sv
// SPI write-frame decoder.
//
// Turns the byte stream of one SPI chip-select frame into register-write strobes.
// Frame layout: command byte 0xA5, one address byte, then any number of
// DATA_BYTES-byte words. Each word goes out as one write, and the address
// advances after every write. Any other command byte makes the decoder skip
// the rest of the frame and report cmd_err.
//
// Parameters
//   ADDR_W     write-address width, 1..8 (taken from the low bits of the address byte)
//   DATA_BYTES bytes per write word, 1..4
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               synchronous active-low reset
//   byte_valid          one-cycle strobe: byte_data_recieved holds a received byte
//   byte_data_recieved  received SPI byte
//   ssel_active         chip-select asserted (frame in progress)
//   ssel_endmessage     one-cycle strobe at chip-select deassertion
//   wr_en               one-cycle write strobe
//   wr_addr             write address, valid with wr_en
//   wr_data             write word, first received byte in the MSBs, valid with wr_en
//   cmd_err             one-cycle strobe: unknown command byte
//   frame_err           one-cycle strobe: frame ended mid-word or before the address byte
//   busy                decoder is inside a frame (not idle)
//   frame_cnt           number of error-free completed write frames, wraps at 8 bits
module spi_frame_decoder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data_recieved,
  input  logic                    ssel_active,
  input  logic                    ssel_endmessage,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    cmd_err,
  output logic                    frame_err,
  output logic                    busy,
  output logic [7:0]              frame_cnt
);

  localparam int unsigned WdataW  = 8 * DATA_BYTES;
  localparam int unsigned CntW    = $clog2(DATA_BYTES + 1);
  localparam logic [7:0]  CmdWrite = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StDrop
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WdataW-1:0]   word_q;
  logic [CntW-1:0]     cnt_q;
  logic                done_q;   // at least one write issued in this frame
  logic                ssel_q;   // ssel_active from the previous cycle

  // State of the frame after the current byte has been applied. The frame-end
  // logic looks at these values, so a byte arriving together with the frame
  // end is always consumed first.
  state_e              st_b;
  logic [ADDR_W-1:0]   addr_b;
  logic [WdataW-1:0]   word_b;
  logic [CntW-1:0]     cnt_b;
  logic                done_b;
  logic                wr_fire;
  logic                cmd_bad;
  logic [WdataW+7:0]   shifted;

  logic                frame_end;
  logic                frame_start;

  // A chip-select release with no ssel_endmessage strobe also ends the frame.
  assign frame_end   = ssel_endmessage | (ssel_q & ~ssel_active);
  // A frame starts only on a rising chip-select. After reset the decoder
  // therefore waits for a fresh assertion and ignores the tail of an
  // interrupted frame.
  assign frame_start = ssel_active & ~ssel_q;

  assign busy = (state_q != StIdle);

  always_comb begin
    st_b    = state_q;
    addr_b  = addr_q;
    word_b  = word_q;
    cnt_b   = cnt_q;
    done_b  = done_q;
    wr_fire = 1'b0;
    cmd_bad = 1'b0;
    // Concatenate and keep the low bits: this shifts MSB-first and also
    // works when the word is a single byte.
    shifted = {word_q, byte_data_recieved};

    if (byte_valid) begin
      unique case (state_q)
        StCmd: begin
          if (byte_data_recieved == CmdWrite) begin
            st_b = StAddr;
          end else begin
            st_b    = StDrop;
            cmd_bad = 1'b1;
          end
        end
        StAddr: begin
          addr_b = byte_data_recieved[ADDR_W-1:0];
          cnt_b  = '0;
          done_b = 1'b0;
          st_b   = StData;
        end
        StData: begin
          word_b = shifted[WdataW-1:0];
          if (cnt_q == CntW'(DATA_BYTES - 1)) begin
            wr_fire = 1'b1;
            cnt_b   = '0;
            done_b  = 1'b1;
          end else begin
            cnt_b = cnt_q + 1'b1;
          end
        end
        default: begin
          // Idle and drop states ignore bytes.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      // Treated as "already asserted" so that a chip-select that is still
      // high when reset is released does not count as a new frame.
      ssel_q    <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cmd_err   <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      ssel_q    <= ssel_active;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= cmd_bad;

      state_q <= st_b;
      addr_q  <= addr_b;
      word_q  <= word_b;
      cnt_q   <= cnt_b;
      done_q  <= done_b;

      if (wr_fire) begin
        wr_en   <= 1'b1;
        wr_addr <= addr_b;
        wr_data <= word_b;
        addr_q  <= addr_b + 1'b1;
      end

      if (state_q == StIdle) begin
        if (frame_start) begin
          state_q <= StCmd;
        end
      end else if (frame_end) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        word_q  <= '0;
        done_q  <= 1'b0;
        unique case (st_b)
          StCmd, StAddr: frame_err <= 1'b1;
          StData: begin
            if (cnt_b != '0) begin
              frame_err <= 1'b1;
            end else if (done_b) begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          default: begin
            // A dropped frame ends silently; cmd_err has already been reported.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
module tb_spi_frame_decoder;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_BYTES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data_recieved = 8'h00;
  logic        ssel_active = 1'b0;
  logic        ssel_endmessage = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cmd_err;
  logic        frame_err;
  logic        busy;
  logic [7:0]  frame_cnt;

  spi_frame_decoder #(
    .ADDR_W     (ADDR_W),
    .DATA_BYTES (DATA_BYTES)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .byte_valid         (byte_valid),
    .byte_data_recieved (byte_data_recieved),
    .ssel_active        (ssel_active),
    .ssel_endmessage    (ssel_endmessage),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .cmd_err            (cmd_err),
    .frame_err          (frame_err),
    .busy               (busy),
    .frame_cnt          (frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] exp_q[$];      // expected writes {addr, data}
  logic [7:0]  exp_fcnt = 8'h00;
  int          cmd_seen  = 0;
  int          ferr_seen = 0;
  logic        wr_prev   = 1'b0;
  logic [7:0]  fb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        check("wr_gap", {31'd0, wr_prev}, 32'd0);
        check("wr_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {24'd0, wr_addr}, {24'd0, e[23:16]});
          check("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
        end
      end
      if (cmd_err)   cmd_seen++;
      if (frame_err) ferr_seen++;
      wr_prev = wr_en;
    end else begin
      wr_prev = 1'b0;
    end
  end

  // Reference model for ADDR_W=8, DATA_BYTES=2.
  task automatic model(input logic [7:0] b[$], output int cmd, output int ferr);
    cmd  = 0;
    ferr = 0;
    if (b.size() == 0) begin
      ferr = 1;
    end else if (b[0] != 8'hA5) begin
      cmd = 1;
    end else if (b.size() == 1) begin
      ferr = 1;
    end else begin
      logic [7:0] a;
      int n;
      a = b[1];
      n = b.size() - 2;
      for (int i = 0; i + 1 < n; i += 2) begin
        exp_q.push_back({a, b[2+i], b[3+i]});
        a = a + 8'd1;
      end
      if ((n % 2) != 0) ferr = 1;
      else if (n > 0) exp_fcnt = exp_fcnt + 8'd1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit with_end);
    @(posedge clk); #1;
    byte_valid         = 1'b1;
    byte_data_recieved = b;
    if (with_end) begin
      ssel_endmessage = 1'b1;
      ssel_active     = 1'b0;
    end
    @(posedge clk); #1;
    byte_valid      = 1'b0;
    ssel_endmessage = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // end_mode: 0 = separate end strobe, 1 = end strobe with last byte,
  // 2 = chip-select release only.
  task automatic run_frame(input string name, input logic [7:0] b[$], input int end_mode);
    int exp_cmd, exp_ferr, cmd0, ferr0;
    model(b, exp_cmd, exp_ferr);
    cmd0  = cmd_seen;
    ferr0 = ferr_seen;
    @(posedge clk); #1 ssel_active = 1'b1;
    @(posedge clk); #1;
    check({name, ":busy_in"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < b.size(); i++) begin
      drive_byte(b[i], end_mode == 1 && i == b.size() - 1);
    end
    if (end_mode != 1 || b.size() == 0) begin
      @(posedge clk); #1;
      ssel_active = 1'b0;
      if (end_mode != 2) ssel_endmessage = 1'b1;
      @(posedge clk); #1 ssel_endmessage = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, ":cmd_err"},   cmd_seen - cmd0,   exp_cmd);
    check({name, ":frame_err"}, ferr_seen - ferr0, exp_ferr);
    check({name, ":wr_left"},   exp_q.size(),      32'd0);
    check({name, ":frame_cnt"}, {24'd0, frame_cnt}, {24'd0, exp_fcnt});
    check({name, ":busy_out"},  {31'd0, busy},     32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cmd0, ferr0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:wr_en",     {31'd0, wr_en},     32'd0);
    check("rst:busy",      {31'd0, busy},      32'd0);
    check("rst:frame_cnt", {24'd0, frame_cnt}, 32'd0);
    check("rst:wr_data",   {16'd0, wr_data},   32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Bytes while idle are ignored.
    drive_byte(8'hA5, 1'b0);
    check("idle:busy", {31'd0, busy}, 32'd0);

    fb = {8'hA5, 8'h10, 8'h12, 8'h34};
    run_frame("single_write", fb, 0);
    fb = {8'hA5, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame("burst_wrap", fb, 0);
    fb = {8'h3C, 8'h01, 8'h02};
    run_frame("bad_cmd", fb, 0);
    fb = {8'hA5, 8'h20, 8'h11};
    run_frame("partial", fb, 0);
    fb = {8'hA5, 8'h30, 8'h56, 8'h78};
    run_frame("end_with_last", fb, 1);
    fb = {8'hA5, 8'h31, 8'h9A, 8'hBC};
    run_frame("ssel_drop", fb, 2);
    fb = {8'hA5};
    run_frame("no_addr", fb, 0);
    fb = {8'hA5, 8'h50};
    run_frame("no_data", fb, 0);
    fb = {};
    run_frame("empty", fb, 2);

    for (int f = 0; f < 8; f++) begin
      int len;
      fb  = {};
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        if (i == 0 && $urandom_range(0, 3) != 0) fb.push_back(8'hA5);
        else fb.push_back(8'($urandom_range(0, 255)));
      end
      run_frame($sformatf("rand%0d", f), fb, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a frame.
    cmd0  = cmd_seen;
    ferr0 = ferr_seen;
    @(posedge clk); #1 ssel_active = 1'b1;
    repeat (2) @(posedge clk);
    drive_byte(8'hA5, 1'b0);
    drive_byte(8'h40, 1'b0);
    drive_byte(8'h77, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst:wr_en",     {31'd0, wr_en},     32'd0);
    check("midrst:cmd_err",   {31'd0, cmd_err},   32'd0);
    check("midrst:frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst:busy",      {31'd0, busy},      32'd0);
    check("midrst:wr_addr",   {24'd0, wr_addr},   32'd0);
    check("midrst:wr_data",   {16'd0, wr_data},   32'd0);
    check("midrst:frame_cnt", {24'd0, frame_cnt}, 32'd0);
    exp_fcnt = 8'h00;
    rst_n    = 1'b1;
    drive_byte(8'h88, 1'b0);
    drive_byte(8'h99, 1'b0);
    check("midrst:busy_after", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    ssel_active     = 1'b0;
    ssel_endmessage = 1'b1;
    @(posedge clk); #1 ssel_endmessage = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst:pulses", (cmd_seen - cmd0) + (ferr_seen - ferr0), 32'd0);

    fb = {8'hA5, 8'h41, 8'h12, 8'h34, 8'h56, 8'h78};
    run_frame("after_rst", fb, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
